// File: rtl/store_pkg.sv
// Shared AXI write constants and the load/store FSM state encoding.
// The fetch unit imports this package as well.
package store_pkg;

  localparam logic [2:0] SIZE_4B       = 3'b010;
  localparam logic [1:0] BURST_INCR    = 2'b01;
  localparam logic [3:0] CACHE_DEFAULT = 4'b0011;
  localparam logic [1:0] RESP_OKAY     = 2'b00;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ADDR_DATA = 2'd1,
    RESP      = 2'd2
  } state_t;

endpackage

// File: rtl/store.sv
// Single-beat AXI4 write master for the core's store path: one 32-bit store
// in flight, completion reported as a one-cycle O_VALID pulse with BRESP.
module store
  import store_pkg::*;
#(
  parameter int C_M_AXI_THREAD_ID_WIDTH = 1,
  parameter int C_M_AXI_ADDR_WIDTH      = 32,
  parameter int C_M_AXI_DATA_WIDTH      = 32,
  parameter int C_M_AXI_AWUSER_WIDTH    = 1,
  parameter int C_M_AXI_WUSER_WIDTH     = 4,
  parameter int C_M_AXI_BUSER_WIDTH     = 1
) (
  input  logic                               CLK,
  input  logic                               RST,

  output logic                               MEM_WAIT,
  input  logic                               I_VALID,
  input  logic [31:0]                        I_ADDR,
  input  logic [31:0]                        I_DATA,
  input  logic [3:0]                         I_STRB,
  output logic                               O_VALID,
  output logic                               O_ERR,
  output logic [1:0]                         O_RESP,
  output state_t                             DBG_STATE,

  output logic [C_M_AXI_THREAD_ID_WIDTH-1:0] M_AXI_AWID,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]      M_AXI_AWADDR,
  output logic [7:0]                         M_AXI_AWLEN,
  output logic [2:0]                         M_AXI_AWSIZE,
  output logic [1:0]                         M_AXI_AWBURST,
  output logic                               M_AXI_AWLOCK,
  output logic [3:0]                         M_AXI_AWCACHE,
  output logic [2:0]                         M_AXI_AWPROT,
  output logic [3:0]                         M_AXI_AWQOS,
  output logic [C_M_AXI_AWUSER_WIDTH-1:0]    M_AXI_AWUSER,
  output logic                               M_AXI_AWVALID,
  input  logic                               M_AXI_AWREADY,

  output logic [C_M_AXI_DATA_WIDTH-1:0]      M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0]    M_AXI_WSTRB,
  output logic                               M_AXI_WLAST,
  output logic [C_M_AXI_WUSER_WIDTH-1:0]     M_AXI_WUSER,
  output logic                               M_AXI_WVALID,
  input  logic                               M_AXI_WREADY,

  input  logic [C_M_AXI_THREAD_ID_WIDTH-1:0] M_AXI_BID,
  input  logic [1:0]                         M_AXI_BRESP,
  input  logic [C_M_AXI_BUSER_WIDTH-1:0]     M_AXI_BUSER,
  input  logic                               M_AXI_BVALID,
  output logic                               M_AXI_BREADY
);

  state_t      state_q;
  logic [29:0] addr_q;
  logic [31:0] data_q;
  logic [3:0]  strb_q;
  logic        aw_valid_q;
  logic        w_valid_q;
  logic        o_valid_q;
  logic        o_err_q;
  logic [1:0]  o_resp_q;
  logic        aw_done;
  logic        w_done;
  logic        unused_ok;

  // Handshakes: a transfer happens on a rising edge where VALID and READY are
  // both high; VALID never drops and payload never changes before that edge.
  assign aw_done = !aw_valid_q || M_AXI_AWREADY;
  assign w_done  = !w_valid_q  || M_AXI_WREADY;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      data_q     <= '0;
      strb_q     <= '0;
      aw_valid_q <= 1'b0;
      w_valid_q  <= 1'b0;
      o_valid_q  <= 1'b0;
      o_err_q    <= 1'b0;
      o_resp_q   <= RESP_OKAY;
    end else begin
      o_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (I_VALID) begin
            addr_q     <= I_ADDR[31:2];
            data_q     <= I_DATA;
            strb_q     <= I_STRB;
            aw_valid_q <= 1'b1;
            w_valid_q  <= 1'b1;
            state_q    <= ADDR_DATA;
          end
        end
        ADDR_DATA: begin
          if (aw_valid_q && M_AXI_AWREADY) aw_valid_q <= 1'b0;
          if (w_valid_q && M_AXI_WREADY)   w_valid_q  <= 1'b0;
          if (aw_done && w_done)           state_q    <= RESP;
        end
        RESP: begin
          if (M_AXI_BVALID) begin
            o_resp_q  <= M_AXI_BRESP;
            o_err_q   <= (M_AXI_BRESP != RESP_OKAY);
            o_valid_q <= 1'b1;
            state_q   <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign MEM_WAIT  = (state_q != IDLE);
  assign DBG_STATE = state_q;
  assign O_VALID   = o_valid_q;
  assign O_ERR     = o_err_q;
  assign O_RESP    = o_resp_q;

  assign M_AXI_AWID    = '0;
  assign M_AXI_AWADDR  = C_M_AXI_ADDR_WIDTH'({addr_q, 2'b00});
  assign M_AXI_AWLEN   = 8'd0;
  assign M_AXI_AWSIZE  = SIZE_4B;
  assign M_AXI_AWBURST = BURST_INCR;
  assign M_AXI_AWLOCK  = 1'b0;
  assign M_AXI_AWCACHE = CACHE_DEFAULT;
  assign M_AXI_AWPROT  = 3'b000;
  assign M_AXI_AWQOS   = 4'd0;
  assign M_AXI_AWUSER  = '0;
  assign M_AXI_AWVALID = aw_valid_q;

  assign M_AXI_WDATA  = data_q;
  assign M_AXI_WSTRB  = strb_q;
  assign M_AXI_WLAST  = w_valid_q;
  assign M_AXI_WUSER  = '0;
  assign M_AXI_WVALID = w_valid_q;

  assign M_AXI_BREADY = (state_q == RESP);

  // Byte lanes come from WSTRB; write ID and user sideband are not used.
  assign unused_ok = ^{I_ADDR[1:0], M_AXI_BID, M_AXI_BUSER};

endmodule

// File: tb/tb_store.sv
// Bench for store: transaction-queue reference model, per-cycle compare on the
// falling edge, directed scenarios followed by randomized slave/requester traffic.
module tb_store;
  import store_pkg::*;

  logic        CLK = 1'b0;
  logic        RST;
  logic        MEM_WAIT;
  logic        I_VALID;
  logic [31:0] I_ADDR;
  logic [31:0] I_DATA;
  logic [3:0]  I_STRB;
  logic        O_VALID;
  logic        O_ERR;
  logic [1:0]  O_RESP;
  state_t      dbg_state;

  logic [0:0]  AWID;
  logic [31:0] AWADDR;
  logic [7:0]  AWLEN;
  logic [2:0]  AWSIZE;
  logic [1:0]  AWBURST;
  logic        AWLOCK;
  logic [3:0]  AWCACHE;
  logic [2:0]  AWPROT;
  logic [3:0]  AWQOS;
  logic [0:0]  AWUSER;
  logic        AWVALID;
  logic        AWREADY;
  logic [31:0] WDATA;
  logic [3:0]  WSTRB;
  logic        WLAST;
  logic [3:0]  WUSER;
  logic        WVALID;
  logic        WREADY;
  logic [0:0]  BID;
  logic [1:0]  BRESP;
  logic [0:0]  BUSER;
  logic        BVALID;
  logic        BREADY;

  store dut (
    .CLK(CLK), .RST(RST), .MEM_WAIT(MEM_WAIT),
    .I_VALID(I_VALID), .I_ADDR(I_ADDR), .I_DATA(I_DATA), .I_STRB(I_STRB),
    .O_VALID(O_VALID), .O_ERR(O_ERR), .O_RESP(O_RESP), .DBG_STATE(dbg_state),
    .M_AXI_AWID(AWID), .M_AXI_AWADDR(AWADDR), .M_AXI_AWLEN(AWLEN),
    .M_AXI_AWSIZE(AWSIZE), .M_AXI_AWBURST(AWBURST), .M_AXI_AWLOCK(AWLOCK),
    .M_AXI_AWCACHE(AWCACHE), .M_AXI_AWPROT(AWPROT), .M_AXI_AWQOS(AWQOS),
    .M_AXI_AWUSER(AWUSER), .M_AXI_AWVALID(AWVALID), .M_AXI_AWREADY(AWREADY),
    .M_AXI_WDATA(WDATA), .M_AXI_WSTRB(WSTRB), .M_AXI_WLAST(WLAST),
    .M_AXI_WUSER(WUSER), .M_AXI_WVALID(WVALID), .M_AXI_WREADY(WREADY),
    .M_AXI_BID(BID), .M_AXI_BRESP(BRESP), .M_AXI_BUSER(BUSER),
    .M_AXI_BVALID(BVALID), .M_AXI_BREADY(BREADY)
  );

  // ---------------- clock / reset ----------------
  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;
  bit done   = 1'b0;
  int aw_hs_cnt = 0;
  int ov_cnt    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // One queue entry {addr, data, strb} per accepted store; aw_left/w_left say
  // which channel of the head entry has not yet transferred.
  logic [67:0] exp_q[$];
  bit          aw_left = 1'b0;
  bit          w_left  = 1'b0;
  bit          m_ov    = 1'b0;
  bit          m_err   = 1'b0;
  logic [1:0]  m_resp  = 2'b00;

  function automatic bit m_busy();
    return exp_q.size() != 0;
  endfunction

  function automatic bit m_in_resp();
    return m_busy() && !aw_left && !w_left;
  endfunction

  always @(posedge CLK) begin
    if (RST) begin
      exp_q.delete();
      aw_left = 1'b0;
      w_left  = 1'b0;
      m_ov    = 1'b0;
      m_err   = 1'b0;
      m_resp  = 2'b00;
    end else begin
      m_ov = 1'b0;
      if (!m_busy()) begin
        if (I_VALID) begin
          exp_q.push_back({I_ADDR, I_DATA, I_STRB});
          aw_left = 1'b1;
          w_left  = 1'b1;
        end
      end else if (aw_left || w_left) begin
        if (aw_left && AWREADY) aw_left = 1'b0;
        if (w_left && WREADY)   w_left  = 1'b0;
      end else if (BVALID) begin
        m_ov   = 1'b1;
        m_resp = BRESP;
        m_err  = (BRESP != 2'b00);
        void'(exp_q.pop_front());
      end
    end
  end

  // ---------------- scoreboard compare ----------------
  always @(negedge CLK) begin
    logic [67:0] head;
    state_t      exp_state;
    if (chk_en && !done) begin
      head = m_busy() ? exp_q[0] : 68'd0;
      exp_state = !m_busy() ? IDLE : (aw_left || w_left) ? ADDR_DATA : RESP;
      chk("mem_wait", 32'(MEM_WAIT), 32'(m_busy()));
      chk("awvalid",  32'(AWVALID),  32'(aw_left));
      chk("wvalid",   32'(WVALID),   32'(w_left));
      chk("wlast",    32'(WLAST),    32'(w_left));
      chk("bready",   32'(BREADY),   32'(m_in_resp()));
      chk("o_valid",  32'(O_VALID),  32'(m_ov));
      chk("o_err",    32'(O_ERR),    32'(m_err));
      chk("o_resp",   32'(O_RESP),   32'(m_resp));
      chk("state",    32'(dbg_state), 32'(exp_state));
      chk("aw_const", {AWLEN, AWSIZE, AWBURST, AWLOCK, AWCACHE, AWPROT, AWQOS, 7'd0},
          {8'd0, 3'b010, 2'b01, 1'b0, 4'b0011, 3'd0, 4'd0, 7'd0});
      chk("user_id",  32'({AWID, AWUSER, WUSER}), 32'd0);
      if (aw_left) chk("awaddr", AWADDR, {head[67:38], 2'b00});
      if (w_left) begin
        chk("wdata", WDATA, head[35:4]);
        chk("wstrb", 32'(WSTRB), 32'(head[3:0]));
      end
      if (AWVALID && AWREADY) aw_hs_cnt++;
      if (O_VALID) ov_cnt++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic request(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    I_VALID = 1'b1;
    I_ADDR  = a;
    I_DATA  = d;
    I_STRB  = s;
  endtask

  int rdy_pct;
  int b_pct;

  initial begin
    RST = 1'b1; I_VALID = 1'b0; I_ADDR = '0; I_DATA = '0; I_STRB = '0;
    AWREADY = 1'b0; WREADY = 1'b0; BVALID = 1'b0; BRESP = 2'b00;
    BID = '0; BUSER = '0;
    step();
    chk_en = 1'b1;
    step(); step();
    RST = 1'b0;
    #3;
    chk("rst_awaddr", AWADDR, 32'd0);
    chk("rst_wdata",  WDATA,  32'd0);
    chk("rst_mwait",  32'(MEM_WAIT), 32'd0);

    // Basic store with minimum turnaround.
    request(32'h0000_1004, 32'hDEAD_BEEF, 4'hF);
    AWREADY = 1'b1; WREADY = 1'b1;
    step();                                   // accept
    I_VALID = 1'b0;
    #3;
    chk("t30_awvalid", 32'(AWVALID), 32'd1);
    chk("t30_awaddr",  AWADDR, 32'h0000_1004);
    chk("t30_wdata",   WDATA,  32'hDEAD_BEEF);
    chk("t30_wlast",   32'(WLAST), 32'd1);
    step();                                   // AW + W transfer
    BVALID = 1'b1; BRESP = 2'b00;
    #3;
    chk("t30_bready", 32'(BREADY), 32'd1);
    step();                                   // B transfer
    BVALID = 1'b0;
    request(32'h0000_0010, 32'h0000_0001, 4'h1);
    #3;
    chk("t30_ovalid", 32'(O_VALID),  32'd1);
    chk("t30_mwait",  32'(MEM_WAIT), 32'd0);
    chk("t30_oerr",   32'(O_ERR),    32'd0);
    step();                                   // back-to-back accept
    I_VALID = 1'b0;
    #3;
    chk("t30_ovalid_pulse", 32'(O_VALID), 32'd0);
    chk("t30_reaccept",     32'(MEM_WAIT), 32'd1);
    step();
    BVALID = 1'b1;
    step();
    BVALID = 1'b0;

    // W accepted three cycles before AW.
    request(32'h0000_3000, 32'hCAFE_0001, 4'hF);
    AWREADY = 1'b0; WREADY = 1'b1;
    step();
    I_VALID = 1'b0;
    step();                                   // W transfer only
    WREADY = 1'b0;
    #3;
    chk("t31_wvalid",  32'(WVALID),  32'd0);
    chk("t31_awvalid", 32'(AWVALID), 32'd1);
    chk("t31_bready",  32'(BREADY),  32'd0);
    step(); step();
    AWREADY = 1'b1;
    #3;
    chk("t31_awaddr_held", AWADDR, 32'h0000_3000);
    step();                                   // AW transfer
    AWREADY = 1'b0; BVALID = 1'b1; BRESP = 2'b00;
    #3;
    chk("t31_bready_after", 32'(BREADY), 32'd1);
    step();
    BVALID = 1'b0;
    #3;
    chk("t31_ovalid", 32'(O_VALID), 32'd1);

    // Unaligned address, single-lane strobe, then SLVERR response.
    AWREADY = 1'b1; WREADY = 1'b1;
    request(32'h0000_2003, 32'h1234_5678, 4'b1000);
    step();
    I_VALID = 1'b0;
    #3;
    chk("t32_awaddr", AWADDR, 32'h0000_2000);
    chk("t32_wstrb",  32'(WSTRB), 32'h8);
    step();
    BVALID = 1'b1; BRESP = 2'b10;
    step();
    BVALID = 1'b0; BRESP = 2'b00;
    #3;
    chk("t33_ovalid", 32'(O_VALID), 32'd1);
    chk("t33_oerr",   32'(O_ERR),   32'd1);
    chk("t33_oresp",  32'(O_RESP),  32'h2);
    step();
    #3;
    chk("t33_oerr_hold", 32'(O_ERR), 32'd1);
    request(32'h0000_0004, 32'h0000_00AA, 4'hF);
    step();
    I_VALID = 1'b0;
    step();
    BVALID = 1'b1;
    step();
    BVALID = 1'b0;
    #3;
    chk("t33_oerr_clear", 32'(O_ERR),  32'd0);
    chk("t33_oresp_okay", 32'(O_RESP), 32'd0);

    // Reset while waiting for B; I_VALID during reset must be ignored.
    request(32'h0000_5000, 32'h5555_AAAA, 4'hF);
    step();
    I_VALID = 1'b0;
    step();
    #3;
    chk("t34_in_resp", 32'(BREADY), 32'd1);
    RST = 1'b1;
    request(32'h0000_6000, 32'h6666_6666, 4'hF);
    step();
    RST = 1'b0; I_VALID = 1'b0;
    #3;
    chk("t34_awvalid", 32'(AWVALID),  32'd0);
    chk("t34_wvalid",  32'(WVALID),   32'd0);
    chk("t34_bready",  32'(BREADY),   32'd0);
    chk("t34_mwait",   32'(MEM_WAIT), 32'd0);
    chk("t34_ovalid",  32'(O_VALID),  32'd0);
    chk("t34_awaddr",  AWADDR,        32'd0);

    // Request held through a busy period: exactly one extra store.
    step();
    aw_hs_cnt = 0; ov_cnt = 0;
    request(32'h0000_0040, 32'h0BAD_F00D, 4'hF);
    step();                                   // accept 1
    step();                                   // AW + W
    BVALID = 1'b1;
    step();                                   // B
    BVALID = 1'b0;
    step();                                   // accept 2
    I_VALID = 1'b0;
    step();
    BVALID = 1'b1;
    step();
    BVALID = 1'b0;
    step(); step();
    #3;
    chk("t35_aw_count", 32'(aw_hs_cnt), 32'd2);
    chk("t35_ov_count", 32'(ov_cnt),    32'd2);

    // Randomized traffic with random slave readiness and stray BVALID.
    for (int i = 0; i < 3000; i++) begin
      if (i % 500 == 0) begin
        rdy_pct = $urandom_range(20, 100);
        b_pct   = $urandom_range(20, 100);
      end
      RST     = ($urandom_range(0, 199) == 0);
      I_VALID = ($urandom_range(0, 2) == 0);
      I_ADDR  = $urandom;
      I_DATA  = $urandom;
      I_STRB  = 4'($urandom_range(0, 15));
      AWREADY = ($urandom_range(1, 100) <= rdy_pct);
      WREADY  = ($urandom_range(1, 100) <= rdy_pct);
      BVALID  = (m_in_resp() && ($urandom_range(1, 100) <= b_pct)) ||
                ($urandom_range(0, 19) == 0);
      BRESP   = 2'($urandom_range(0, 3));
      BID     = 1'($urandom_range(0, 1));
      BUSER   = 1'($urandom_range(0, 1));
      step();
    end
    RST = 1'b0; I_VALID = 1'b0; BVALID = 1'b0;
    step(); step();
    done = 1'b1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
